// File: rtl/lut_interp_mc.sv
// lut_interp_mc: multi-channel table-driven linear interpolator sharing one 5-stage datapath.
// Optional macro INTERP_ROUND_EN: round half up in the final shift instead of flooring.
module lut_interp_mc #(
    parameter int unsigned CH     = 4,
    parameter int unsigned INT_W  = 10,
    parameter int unsigned FRAC_W = 8,
    parameter int unsigned DW     = 24,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned BASE   = 273
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sta,
    input  logic [CH*(INT_W+FRAC_W)-1:0]  X,
    input  logic                          wr_en,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic signed [DW-1:0]          wr_data,
    output logic [CH*DW-1:0]              Y,
    output logic [CH-1:0]                 oor,
    output logic                          busy,
    output logic                          done_sig
);
    localparam int unsigned XW  = INT_W + FRAC_W;
    localparam int unsigned CW  = (CH > 1) ? $clog2(CH) : 1;
    localparam int unsigned FW  = FRAC_W + 1;
    localparam int unsigned DDW = DW + 1;
    localparam int unsigned PW  = DDW + FW + 1;
    localparam int unsigned SW  = PW - FRAC_W;
    localparam logic signed [DW-1:0] Y_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] Y_MIN = ~Y_MAX;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [XW-1:0]         r_x [CH];
    logic signed [DW-1:0]  r_tbl [DEPTH];

    logic                  r_s0_v, r_s1_v, r_s2_v, r_s3_v;
    logic [CW-1:0]         r_s0_ch, r_s1_ch, r_s2_ch, r_s3_ch;
    logic [ADDR_W-1:0]     r_s0_idx;
    logic [FW-1:0]         r_s0_f, r_s1_f, r_s2_f;
    logic                  r_s0_oor, r_s1_oor, r_s2_oor, r_s3_oor;
    logic signed [DW-1:0]  r_s1_y0, r_s1_y1, r_s2_y0, r_s3_y0;
    logic signed [DDW-1:0] r_s2_d;
    logic signed [PW-1:0]  r_s3_p;

    logic [XW-1:0]         w_xk;
    int                    w_n;
    logic [ADDR_W-1:0]     w_idx;
    logic [FW-1:0]         w_f;
    logic                  w_oor;
    logic signed [PW-1:0]  w_pr;
    logic signed [SW-1:0]  w_sum;
    logic signed [DW-1:0]  w_y;

    // S0: table index and fraction for the channel being issued, clamped to the table span
    always_comb begin
        w_xk  = r_x[r_cnt];
        w_n   = int'(w_xk[XW-1 -: INT_W]) - int'(BASE);
        w_idx = ADDR_W'(w_n);
        w_f   = {1'b0, w_xk[FRAC_W-1:0]};
        w_oor = 1'b0;
        if (w_n < 0) begin
            w_idx = '0;
            w_f   = '0;
            w_oor = 1'b1;
        end else if (w_n > int'(DEPTH) - 2) begin
            w_idx = ADDR_W'(DEPTH - 2);
            w_f   = FW'(1) << FRAC_W;
            w_oor = 1'b1;
        end
    end

    // S4: scale back the product, add the base sample, saturate
    always_comb begin
`ifdef INTERP_ROUND_EN
        w_pr = r_s3_p + PW'(2 ** (FRAC_W - 1));
`else
        w_pr = r_s3_p;
`endif
        w_sum = SW'(r_s3_y0) + SW'(w_pr >>> FRAC_W);
        if (w_sum > SW'(Y_MAX))
            w_y = Y_MAX;
        else if (w_sum < SW'(Y_MIN))
            w_y = Y_MIN;
        else
            w_y = DW'(w_sum);
    end

    // Control FSM, stage valids and result slots
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            busy     <= 1'b0;
            done_sig <= 1'b0;
            r_s0_v   <= 1'b0;
            r_s1_v   <= 1'b0;
            r_s2_v   <= 1'b0;
            r_s3_v   <= 1'b0;
            Y        <= '0;
            oor      <= '0;
        end else begin
            done_sig <= 1'b0;
            r_s0_v   <= 1'b0;
            r_s1_v   <= r_s0_v;
            r_s2_v   <= r_s1_v;
            r_s3_v   <= r_s2_v;
            if (r_s3_v) begin
                Y[r_s3_ch*DW +: DW] <= w_y;
                oor[r_s3_ch]        <= r_s3_oor;
            end
            case (r_state)
                S_IDLE: begin
                    if (sta) begin
                        r_state <= S_ISSUE;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_s0_v <= 1'b1;
                    if (r_cnt == CW'(CH - 1))
                        r_state <= S_DRAIN;
                    else
                        r_cnt <= r_cnt + CW'(1);
                end
                S_DRAIN: begin
                    if (!(r_s0_v || r_s1_v || r_s2_v || r_s3_v)) begin
                        r_state  <= S_DONE;
                        done_sig <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Table RAM, input latch and datapath registers (valids qualify these, so no reset)
    always_ff @(posedge clk) begin
        if (wr_en && !busy && (32'(wr_addr) < DEPTH))
            r_tbl[wr_addr] <= wr_data;
        if (r_state == S_IDLE && sta) begin
            for (int unsigned k = 0; k < CH; k++)
                r_x[k] <= X[k*XW +: XW];
        end
        r_s0_ch  <= r_cnt;
        r_s0_idx <= w_idx;
        r_s0_f   <= w_f;
        r_s0_oor <= w_oor;

        r_s1_ch  <= r_s0_ch;
        r_s1_y0  <= r_tbl[r_s0_idx];
        r_s1_y1  <= r_tbl[r_s0_idx + ADDR_W'(1)];
        r_s1_f   <= r_s0_f;
        r_s1_oor <= r_s0_oor;

        r_s2_ch  <= r_s1_ch;
        r_s2_y0  <= r_s1_y0;
        r_s2_d   <= DDW'(r_s1_y1) - DDW'(r_s1_y0);
        r_s2_f   <= r_s1_f;
        r_s2_oor <= r_s1_oor;

        r_s3_ch  <= r_s2_ch;
        r_s3_y0  <= r_s2_y0;
        r_s3_p   <= PW'(r_s2_d) * PW'($signed({1'b0, r_s2_f}));
        r_s3_oor <= r_s2_oor;
    end

endmodule

// File: tb/tb_lut_interp_mc.sv
// tb_lut_interp_mc: directed and randomized checks of lut_interp_mc against a run-level reference model.
module tb_lut_interp_mc;
    localparam int CH = 4, INT_W = 10, FRAC_W = 8, DW = 24, ADDR_W = 7, DEPTH = 128, BASE = 273;
    localparam int XW = INT_W + FRAC_W;
`ifdef INTERP_ROUND_EN
    localparam longint RND_Y = 2;
`else
    localparam longint RND_Y = 1;
`endif

    logic                 clk = 1'b0, rst = 1'b1, sta = 1'b0, wr_en = 1'b0;
    logic [CH*XW-1:0]     X = '0;
    logic [ADDR_W-1:0]    wr_addr = '0;
    logic signed [DW-1:0] wr_data = '0;
    logic [CH*DW-1:0]     Y;
    logic [CH-1:0]        oor;
    logic                 busy, done_sig;

    int n_checks = 0, n_errs = 0;

    // reference model state
    longint        m_tbl [DEPTH];
    longint        exp_y [CH];
    logic [CH-1:0] exp_oor = '0;
    bit            exp_busy = 1'b0, exp_done = 1'b0;
    longint        run_y [CH];
    bit            run_oor [CH];
    bit            m_active = 1'b0;
    int            m_age = 0;

    lut_interp_mc #(.CH(CH), .INT_W(INT_W), .FRAC_W(FRAC_W), .DW(DW),
                    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk(clk), .rst(rst), .sta(sta), .X(X), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .Y(Y), .oor(oor), .busy(busy), .done_sig(done_sig)
    );

    always #5 clk = ~clk;

    function automatic logic [XW-1:0] mk(input int i, input int f);
        return XW'(i * (1 << FRAC_W) + f);
    endfunction

    // interpolation straight from the table definition
    function automatic void model_ch(input logic [XW-1:0] x, output longint y, output bit o);
        int n;
        longint y0, y1, f, p;
        n = int'(x[XW-1 -: INT_W]) - BASE;
        if (n < 0) begin
            y = m_tbl[0]; o = 1'b1;
        end else if (n > DEPTH - 2) begin
            y = m_tbl[DEPTH-1]; o = 1'b1;
        end else begin
            y0 = m_tbl[n];
            y1 = m_tbl[n+1];
            f  = longint'(x[FRAC_W-1:0]);
            p  = (y1 - y0) * f;
`ifdef INTERP_ROUND_EN
            p  = p + (64'sd1 <<< (FRAC_W - 1));
`endif
            y  = y0 + (p >>> FRAC_W);
            if (y > (64'sd1 <<< (DW-1)) - 1) y = (64'sd1 <<< (DW-1)) - 1;
            if (y < -(64'sd1 <<< (DW-1)))    y = -(64'sd1 <<< (DW-1));
            o  = 1'b0;
        end
    endfunction

    // run-level timing: slot k retires 5+k edges after acceptance, done at CH+5, idle at CH+6
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0; m_age = 0;
            exp_busy = 1'b0; exp_done = 1'b0; exp_oor = '0;
            for (int k = 0; k < CH; k++) exp_y[k] = 0;
        end else begin
            exp_done = 1'b0;
            if (m_active) begin
                m_age++;
                if (m_age >= 5 && m_age < 5 + CH) begin
                    exp_y[m_age-5]   = run_y[m_age-5];
                    exp_oor[m_age-5] = run_oor[m_age-5];
                end
                if (m_age == CH + 5) exp_done = 1'b1;
                if (m_age == CH + 6) m_active = 1'b0;
            end else begin
                if (wr_en && int'(wr_addr) < DEPTH) m_tbl[wr_addr] = longint'(wr_data);
                if (sta) begin
                    for (int k = 0; k < CH; k++) model_ch(X[k*XW +: XW], run_y[k], run_oor[k]);
                    m_active = 1'b1;
                    m_age    = 0;
                end
            end
            exp_busy = m_active;
        end
    end

    function automatic longint yslot(input int k);
        logic signed [DW-1:0] t;
        t = Y[k*DW +: DW];
        return longint'(t);
    endfunction

    // cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        n_checks++;
        if (busy !== exp_busy) begin
            n_errs++;
            $display("FAIL busy @%0t: got %b expected %b", $time, busy, exp_busy);
        end
        n_checks++;
        if (done_sig !== exp_done) begin
            n_errs++;
            $display("FAIL done_sig @%0t: got %b expected %b", $time, done_sig, exp_done);
        end
        n_checks++;
        if (oor !== exp_oor) begin
            n_errs++;
            $display("FAIL oor @%0t: got %b expected %b", $time, oor, exp_oor);
        end
        for (int k = 0; k < CH; k++) begin
            n_checks++;
            if (yslot(k) !== exp_y[k]) begin
                n_errs++;
                $display("FAIL Y[%0d] @%0t: got %0d expected %0d", k, $time, yslot(k), exp_y[k]);
            end
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [CH*XW-1:0] xv);
        X   = xv;
        sta = 1'b1;
        tick();
        sta = 1'b0;
        X   = {$urandom, $urandom, $urandom};
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (done_sig !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        if (done_sig !== 1'b1) begin
            n_checks++;
            n_errs++;
            $display("FAIL done_timeout: got no done_sig within %0d cycles", lat);
        end
    endtask

    logic [CH*XW-1:0] xa, xc, xr;
    int lat, l2, cnt, d, nw;

    initial begin
        repeat (3) tick();
        for (int k = 0; k < CH; k++) chk($sformatf("reset_Y%0d", k), yslot(k), 0);
        chk("reset_oor", longint'(oor), 0);
        chk("reset_busy", longint'(busy), 0);
        chk("reset_done", longint'(done_sig), 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1; wr_addr = ADDR_W'(i); wr_data = DW'(1000 * i);
            tick();
        end
        wr_en = 1'b0;

        // linear table with clamps on both sides
        xa = {mk(100, 0), mk(399, 0), mk(400, 0), mk(300, 128)};
        start_run(xa);
        wait_done(lat);
        chk("latency_A", lat, 9);
        chk("A_Y0", yslot(0), 27500);
        chk("A_Y1", yslot(1), 127000);
        chk("A_Y2", yslot(2), 126000);
        chk("A_Y3", yslot(3), 0);
        chk("A_oor", longint'(oor), 10);
        tick();

        // reset in the middle of a run
        start_run(xa);
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        chk("midrst_Y0", yslot(0), 0);
        chk("midrst_oor", longint'(oor), 0);
        chk("midrst_busy", longint'(busy), 0);
        tick();
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done_sig === 1'b1) cnt++;
        end
        chk("midrst_no_done", cnt, 0);
        start_run(xa);
        wait_done(lat);
        chk("post_rst_latency", lat, 9);
        chk("post_rst_Y1", yslot(1), 127000);
        tick();

        // negative slope, rounding, and a write issued together with sta
        wr_en = 1'b1; wr_addr = 7'd5; wr_data = 24'sd100;  tick();
        wr_addr = 7'd6; wr_data = -24'sd100; tick();
        wr_addr = 7'd1; wr_data = 24'sd3;
        xc = {mk(274, 0), mk(273, 0), mk(273, 128), mk(278, 64)};
        start_run(xc);
        wr_en = 1'b0;
        wait_done(lat);
        chk("C_Y0_negslope", yslot(0), 50);
        chk("C_Y1_round", yslot(1), RND_Y);
        chk("C_Y2", yslot(2), 0);
        chk("C_Y3_newwrite", yslot(3), 3);
        chk("C_oor", longint'(oor), 0);
        tick();

        // sta and wr_en while busy are both ignored
        start_run(xc);
        tick(); tick();
        sta = 1'b1;
        tick();
        sta = 1'b0;
        wr_en = 1'b1; wr_addr = 7'd5; wr_data = 24'sd7777;
        tick();
        wr_en = 1'b0;
        wait_done(l2);
        chk("hs_latency", 4 + l2, 9);
        tick();
        chk("hs_busy_low", longint'(busy), 0);
        start_run(xc);
        wait_done(lat);
        chk("hs_rerun_latency", lat, 9);
        chk("hs_table_kept", yslot(0), 50);
        tick();

        // randomized runs with table updates and busy-time disturbances
        for (int r = 0; r < 40; r++) begin
            nw = $urandom_range(0, 4);
            for (int w = 0; w < nw; w++) begin
                wr_en = 1'b1; wr_addr = ADDR_W'($urandom); wr_data = DW'($urandom);
                tick();
            end
            wr_en = 1'b0;
            for (int k = 0; k < CH; k++)
                xr[k*XW +: XW] = mk($urandom_range(265, 405), $urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) begin
                wr_en = 1'b1; wr_addr = ADDR_W'($urandom_range(0, 15)); wr_data = DW'($urandom);
            end
            start_run(xr);
            wr_en = 1'b0;
            d = $urandom_range(1, 6);
            repeat (d) tick();
            sta = 1'b1; wr_en = 1'b1; wr_addr = ADDR_W'($urandom); wr_data = DW'($urandom);
            tick();
            sta = 1'b0; wr_en = 1'b0;
            wait_done(lat);
            tick();
        end

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
